// File: rtl/hc00_bist_pkg.sv
// hc00_bist_pkg: shared types and constants for the quad-NAND BIST sequencer.
//   state_t  : sequencer states
//   GATE_N   : number of gates in the array
//   VEC_W    : width of the stimulus vector index
//   VEC_LAST : final vector index of a run
//   nand_exp : ideal gate response for a given A/B pair
package hc00_bist_pkg;

    localparam int GATE_N = 4;
    localparam int VEC_W  = 8;
    localparam logic [VEC_W-1:0] VEC_LAST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CHECK   = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    function automatic logic [GATE_N-1:0] nand_exp(input logic [GATE_N-1:0] a,
                                                   input logic [GATE_N-1:0] b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/hc00_bist_if.sv
// hc00_bist_if: board-control side of the BIST sequencer.
//   start/abort      : single-cycle requests from board control
//   busy/done/pass   : run status
//   fail_mask        : sticky per-gate failure flags, bit n-1 = gate n
//   err_cnt          : saturating count of mismatching vectors
//   first_fail_vec   : index of the first mismatching vector
//   first_fail_valid : first_fail_vec holds a captured value
// master = board control, slave = sequencer.
interface hc00_bist_if #(parameter int ERR_W = 9) ();
    import hc00_bist_pkg::*;

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              pass;
    logic [GATE_N-1:0] fail_mask;
    logic [ERR_W-1:0]  err_cnt;
    logic [VEC_W-1:0]  first_fail_vec;
    logic              first_fail_valid;

    modport master (
        output start, abort,
        input  busy, done, pass, fail_mask, err_cnt, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, fail_mask, err_cnt, first_fail_vec, first_fail_valid
    );

endinterface

// File: rtl/hc00_sync_vec.sv
// hc00_sync_vec: multi-bit flop synchroniser for the gate outputs.
//   clk, rst_n : clock, async active-low reset (flops clear to 0)
//   d          : asynchronous input
//   q          : input after STAGES flops (at least 2)
// Each bit is synchronised independently; the sequencer only samples q
// after it has been stable for longer than the synchroniser depth.
module hc00_sync_vec #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    localparam int ST = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] ff [ST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ST; i++) ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < ST; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[ST-1];

endmodule

// File: rtl/hc00_bist_ctrl.sv
// hc00_bist_ctrl: exhaustive BIST sequencer for a quad 2-input NAND array.
//   clk, rst_n   : clock, async active-low reset
//   ctl          : board-control interface (start/abort in, results out)
//   dut_a, dut_b : gate inputs, A = vec[7:4], B = vec[3:0] while busy
//   dut_y        : gate outputs, asynchronous to clk
//
//   state   | meaning
//   IDLE    | no run, pins driven 0, results from an aborted run (or reset) held
//   SETTLE  | vector driven, settle counter runs 1..SETTLE_EFF
//   CHECK   | compare synchronised outputs, accumulate, step vector
//   DONE_ST | run completed, done/pass valid, results held until next start
module hc00_bist_ctrl
    import hc00_bist_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    hc00_bist_if.slave        ctl,
    output logic [GATE_N-1:0] dut_a,
    output logic [GATE_N-1:0] dut_b,
    input  logic [GATE_N-1:0] dut_y
);
    localparam int SYNC_EFF   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // Settle must cover the synchroniser plus one cycle of stable data.
    localparam int SETTLE_EFF = (SETTLE_CYC < SYNC_EFF + 1) ? SYNC_EFF + 1 : SETTLE_CYC;
    localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [GATE_N-1:0]  fail_q;
    logic [ERR_W-1:0]   err_q;
    logic [VEC_W-1:0]   ffv_q;
    logic               ffvalid_q;
    logic [GATE_N-1:0]  ys;
    logic [GATE_N-1:0]  mis;
    logic               running;
    logic               accept_start;
    logic               abort_run;

    hc00_sync_vec #(.WIDTH(GATE_N), .STAGES(SYNC_EFF)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_y),
        .q     (ys)
    );

    assign running      = (state_q == SETTLE) || (state_q == CHECK);
    assign accept_start = ctl.start && !ctl.abort && !running;
    assign abort_run    = ctl.abort && running;
    assign mis          = ys ^ nand_exp(vec_q[7:4], vec_q[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE_ST: if (accept_start) state_d = SETTLE;
            SETTLE: begin
                if (abort_run)                 state_d = IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = CHECK;
            end
            CHECK: begin
                if (abort_run)               state_d = IDLE;
                else if (vec_q == VEC_LAST)  state_d = DONE_ST;
                else                         state_d = SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '0;
            cnt_q     <= '0;
            fail_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else if (accept_start) begin
            vec_q     <= '0;
            cnt_q     <= CNT_W'(1);
            fail_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else if (!abort_run) begin
            if (state_q == SETTLE && cnt_q != SETTLE_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == CHECK) begin
                if (mis != '0) begin
                    fail_q <= fail_q | mis;
                    if (err_q != '1) err_q <= err_q + 1'b1;
                    if (!ffvalid_q) begin
                        ffv_q     <= vec_q;
                        ffvalid_q <= 1'b1;
                    end
                end
                if (vec_q != VEC_LAST) begin
                    vec_q <= vec_q + 1'b1;
                    cnt_q <= CNT_W'(1);
                end
            end
        end
    end

    assign dut_a                = running ? vec_q[7:4] : '0;
    assign dut_b                = running ? vec_q[3:0] : '0;
    assign ctl.busy             = running;
    assign ctl.done             = (state_q == DONE_ST);
    assign ctl.pass             = (state_q == DONE_ST) && (err_q == '0);
    assign ctl.fail_mask        = fail_q;
    assign ctl.err_cnt          = err_q;
    assign ctl.first_fail_vec   = ffv_q;
    assign ctl.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_hc00_bist_ctrl.sv
// tb_hc00_bist_ctrl: directed bench for hc00_bist_ctrl.
// u9 (ERR_W=9) sees a behavioural gate array with selectable faults;
// u4 (ERR_W=4) sees an AND array so every vector mismatches.
module tb_hc00_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] a9, b9, y9;
    logic [3:0] a4, b4, y4;
    int         fault;
    int         n_cmp;
    int         n_mis;
    int         n;

    hc00_bist_if #(.ERR_W(9)) if9 ();
    hc00_bist_if #(.ERR_W(4)) if4 ();

    hc00_bist_ctrl #(.SETTLE_CYC(4), .SYNC_STAGES(2), .ERR_W(9)) u9 (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (if9.slave),
        .dut_a (a9),
        .dut_b (b9),
        .dut_y (y9)
    );

    hc00_bist_ctrl #(.SETTLE_CYC(4), .SYNC_STAGES(2), .ERR_W(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (if4.slave),
        .dut_a (a4),
        .dut_b (b4),
        .dut_y (y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fault: 0 ideal, 1 gate2 stuck-1, 2 gate4 stuck-0, 4 gate1 stuck-1
    always_comb begin
        y9 = ~(a9 & b9);
        case (fault)
            1: y9 = y9 | 4'b0010;
            2: y9 = y9 & 4'b0111;
            4: y9 = y9 | 4'b0001;
            default: ;
        endcase
        y4 = a4 & b4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a run on u9 and returns the number of edges from the edge that
    // launched start up to and including the one that raised done.
    task automatic run9(input int spur, output int cnt);
        if9.start = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (cnt == 1) begin
                if9.start = 1'b0;
                chk("start_busy",  32'(if9.busy), 32'd1);
                chk("start_err",   32'(if9.err_cnt), 32'd0);
                chk("start_mask",  32'(if9.fail_mask), 32'd0);
                chk("start_valid", 32'(if9.first_fail_valid), 32'd0);
                chk("start_done",  32'(if9.done), 32'd0);
            end
            if (spur != 0 && cnt == spur) if9.start = 1'b1;
            if (spur != 0 && cnt == spur + 1) begin
                if9.start = 1'b0;
                chk("busy_start_vec", 32'({a9, b9}), 32'(spur / 5));
            end
        end while (!if9.done && cnt < 3000);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        fault = 0;
        rst_n = 1'b0;
        if9.start = 1'b0; if9.abort = 1'b0;
        if4.start = 1'b0; if4.abort = 1'b0;
        tick(); tick();

        chk("rst_busy",  32'(if9.busy), 32'd0);
        chk("rst_done",  32'(if9.done), 32'd0);
        chk("rst_pass",  32'(if9.pass), 32'd0);
        chk("rst_pins",  32'({a9, b9}), 32'd0);
        chk("rst_err",   32'(if9.err_cnt), 32'd0);
        chk("rst_mask",  32'(if9.fail_mask), 32'd0);
        chk("rst_ffv",   32'({if9.first_fail_valid, if9.first_fail_vec}), 32'd0);
        rst_n = 1'b1;
        tick(); tick();

        // ideal array
        run9(0, n);
        chk("ideal_latency", 32'(n), 32'd1281);
        chk("ideal_pass",    32'(if9.pass), 32'd1);
        chk("ideal_busy",    32'(if9.busy), 32'd0);
        chk("ideal_err",     32'(if9.err_cnt), 32'd0);
        chk("ideal_mask",    32'(if9.fail_mask), 32'd0);
        chk("ideal_valid",   32'(if9.first_fail_valid), 32'd0);
        chk("ideal_pins",    32'({a9, b9}), 32'd0);
        tick(); tick();
        chk("ideal_hold",    32'({if9.done, if9.pass}), 32'd3);

        // gate 2 stuck at 1, restarted straight from DONE_ST
        fault = 1;
        run9(0, n);
        chk("g2_latency", 32'(n), 32'd1281);
        chk("g2_pass",    32'(if9.pass), 32'd0);
        chk("g2_done",    32'(if9.done), 32'd1);
        chk("g2_mask",    32'(if9.fail_mask), 32'h2);
        chk("g2_err",     32'(if9.err_cnt), 32'd64);
        chk("g2_ffv",     32'(if9.first_fail_vec), 32'h22);
        chk("g2_valid",   32'(if9.first_fail_valid), 32'd1);

        // gate 4 stuck at 0
        fault = 2;
        run9(0, n);
        chk("g4_mask",  32'(if9.fail_mask), 32'h8);
        chk("g4_err",   32'(if9.err_cnt), 32'd192);
        chk("g4_ffv",   32'(if9.first_fail_vec), 32'h00);
        chk("g4_valid", 32'(if9.first_fail_valid), 32'd1);

        // inverted array on the narrow-counter instance
        if4.start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) if4.start = 1'b0;
        end while (!if4.done && n < 3000);
        chk("inv_latency", 32'(n), 32'd1281);
        chk("inv_err",     32'(if4.err_cnt), 32'd15);
        chk("inv_mask",    32'(if4.fail_mask), 32'hF);
        chk("inv_ffv",     32'(if4.first_fail_vec), 32'h00);
        chk("inv_pass",    32'(if4.pass), 32'd0);

        // abort at vector 0x40 with gate 1 stuck at 1, start in the same cycle
        fault = 4;
        if9.start = 1'b1;
        tick();
        if9.start = 1'b0;
        n = 0;
        while ({a9, b9} != 8'h40 && n < 2000) begin
            tick();
            n++;
        end
        chk("abort_reach_vec", 32'({a9, b9}), 32'h40);
        if9.abort = 1'b1;
        if9.start = 1'b1;
        tick();
        if9.abort = 1'b0;
        if9.start = 1'b0;
        chk("abort_busy",  32'(if9.busy), 32'd0);
        chk("abort_done",  32'(if9.done), 32'd0);
        chk("abort_pass",  32'(if9.pass), 32'd0);
        chk("abort_pins",  32'({a9, b9}), 32'd0);
        chk("abort_mask",  32'(if9.fail_mask), 32'h1);
        chk("abort_err",   32'(if9.err_cnt), 32'd16);
        chk("abort_ffv",   32'({if9.first_fail_valid, if9.first_fail_vec}), 32'h111);
        tick();
        chk("abort_idle",  32'(if9.busy), 32'd0);
        run9(0, n);
        chk("rerun_latency", 32'(n), 32'd1281);
        chk("rerun_mask",    32'(if9.fail_mask), 32'h1);
        chk("rerun_err",     32'(if9.err_cnt), 32'd64);
        chk("rerun_ffv",     32'(if9.first_fail_vec), 32'h11);

        // async reset in the middle of a run
        fault = 1;
        if9.start = 1'b1;
        tick();
        if9.start = 1'b0;
        n = 0;
        while ({a9, b9} != 8'h23 && n < 2000) begin
            tick();
            n++;
        end
        chk("prerst_err", 32'(if9.err_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",  32'(if9.busy), 32'd0);
        chk("midrst_pins",  32'({a9, b9}), 32'd0);
        chk("midrst_err",   32'(if9.err_cnt), 32'd0);
        chk("midrst_mask",  32'(if9.fail_mask), 32'd0);
        chk("midrst_ffv",   32'({if9.first_fail_valid, if9.first_fail_vec}), 32'd0);
        chk("midrst_done",  32'({if9.done, if9.pass}), 32'd0);
        tick();
        rst_n = 1'b1;
        fault = 0;
        tick(); tick(); tick();
        run9(100, n);
        chk("postrst_latency", 32'(n), 32'd1281);
        chk("postrst_pass",    32'(if9.pass), 32'd1);
        chk("postrst_err",     32'(if9.err_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hc00_bist_ctrl.md
Name: hc00_bist_ctrl

Overview:
- Built-in self-test sequencer for the quad 2-input NAND array (74HC00 replica or external chip on the test header).
- Drives all 256 combinations of A[4:1]/B[4:1] onto the gate array and waits a programmable settle time.
- Synchronises and samples Y[4:1] and compares it with the ideal NAND result. Accumulates per-gate fail flags, an error count and the first failing vector.
- Sits between the board control logic (start/abort, result LEDs) and the gate array pins.

Parameters:
- SETTLE_CYC, 4, cycles a vector is held before sampling; includes synchroniser latency; values below SYNC_STAGES+1 are clamped to SYNC_STAGES+1.
- SYNC_STAGES, 2, flip-flop stages on DUT_Y (minimum 2).
- ERR_W, 9, width of ERR_CNT (saturating).

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle start request.
- ABORT  in  1  single-cycle abort request.
- DUT_A  out  4  [4:1] gate A inputs.
- DUT_B  out  4  [4:1] gate B inputs.
- DUT_Y  in  4  [4:1] gate outputs, asynchronous to CLK.
- BUSY  out  1  run in progress.
- DONE  out  1  last run completed (not aborted).
- PASS  out  1  DONE and zero errors.
- FAIL_MASK  out  4  [4:1] sticky, gate n produced at least one wrong output.
- ERR_CNT  out  ERR_W  mismatching vectors, saturates at all-ones.
- FIRST_FAIL_VEC  out  8  vector index of first mismatch.
- FIRST_FAIL_VALID  out  1  FIRST_FAIL_VEC holds a captured value.

Behaviour:
- Reset values (async on RST_N low):
  - All outputs 0.
  - State IDLE, vector counter VEC=0, settle counter 0, synchroniser flops 0.
- Vector mapping: VEC[7:0] drives DUT_A[4:1]=VEC[7:4] and DUT_B[4:1]=VEC[3:0], so A[n]=VEC[n+3] and B[n]=VEC[n-1]. EXP[4:1] = ~(DUT_A & DUT_B).
- DUT_Y passes through a SYNC_STAGES flop synchroniser giving Ys. Only Ys is compared.
- State IDLE:
  - DUT_A/DUT_B = 0.
  - START=1 and ABORT=0 moves to SETTLE on the next edge. On that same edge: VEC=0; FAIL_MASK, ERR_CNT, FIRST_FAIL_* and DONE/PASS are cleared; BUSY is set.
- State SETTLE:
  - VEC is driven and the settle counter counts 1..SETTLE_CYC.
  - When the count reaches SETTLE_CYC, move to CHECK.
- State CHECK (one cycle):
  - MIS = Ys ^ EXP.
  - If MIS is not 0: FAIL_MASK |= MIS; ERR_CNT increments (held at max when saturated); if FIRST_FAIL_VALID=0, capture FIRST_FAIL_VEC=VEC and set FIRST_FAIL_VALID.
  - If VEC=255, go to DONE_ST. Otherwise VEC+1 and return to SETTLE with the settle counter reset.
- Per-vector time is SETTLE_CYC+1 cycles. START to DONE = 256*(SETTLE_CYC+1)+1 cycles.
- State DONE_ST:
  - BUSY=0, DONE=1, PASS=(ERR_CNT==0). DUT_A/B return to 0.
  - Results hold until the next accepted START. START restarts exactly as from IDLE.
- ABORT while BUSY:
  - Next edge goes to IDLE with BUSY=0, DONE=0, PASS=0, DUT_A/B=0.
  - FAIL_MASK, ERR_CNT and FIRST_FAIL_* keep their partial values.
- ABORT in IDLE/DONE_ST: no effect.
- START while BUSY: ignored.
- START and ABORT in the same cycle: ABORT wins, no run starts, state unchanged if idle.
- RST_N asserted mid-run: immediate return to reset values. No partial result is kept.
- Unused state encodings return to IDLE.

Decomposition:
- Package hc00_bist_pkg:
  - State enum (IDLE, SETTLE, CHECK, DONE_ST).
  - Constants GATE_N=4 and VEC_W=8, VEC_LAST=255.
  - Function nand_exp(a,b) returning ~(a&b).
- Sub-module hc00_sync_vec: parameterised width/stage flop synchroniser with async active-low reset, used on DUT_Y.

Test Plan:
- Ideal NAND model on DUT_Y, SETTLE_CYC=4, START pulse:
  - DONE rises exactly 1281 cycles after the START edge.
  - PASS=1, ERR_CNT=0, FAIL_MASK=0000, FIRST_FAIL_VALID=0.
- Gate 2 output stuck at 1:
  - DONE with PASS=0, FAIL_MASK=0010, ERR_CNT=64.
  - FIRST_FAIL_VEC=8'h22, FIRST_FAIL_VALID=1.
- Gate 4 output stuck at 0:
  - FAIL_MASK=1000, ERR_CNT=192, FIRST_FAIL_VEC=8'h00.
- All four outputs inverted (AND instead of NAND), ERR_W=4:
  - ERR_CNT saturates at 15, FAIL_MASK=1111, FIRST_FAIL_VEC=8'h00.
- ABORT at VEC=8'h40 with the gate 1 fault injected:
  - BUSY drops next cycle, DONE=0, DUT_A/B=0, partial FAIL_MASK=0001 retained.
  - A START in the abort cycle does not start a run; a START 2 cycles later starts a fresh run with cleared results.
- RST_N pulse low mid-SETTLE:
  - All outputs 0 immediately.
  - A START 3 cycles after release completes normally with PASS=1.
  - A START while BUSY changes neither VEC nor the timing.
